// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: FSM states, key-length legality and GF(2^8) xtime.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2,
        FIN  = 2'd3
    } ks_state_e;

    function automatic bit nk_legal(input int nk);
        return (nk == 4) || (nk == 6) || (nk == 8);
    endfunction

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_expand_serial_if.sv
// Round-key channel of key_expand_serial, for consumers that prefer a bundled port.
interface key_expand_serial_if;

    // A round key moves on every clock edge where rk_valid && rk_ready; while
    // rk_valid is high and no transfer has happened, rk and rk_idx do not change.
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;

    modport master (output rk, output rk_idx, output rk_valid, input rk_ready);
    modport slave  (input rk, input rk_idx, input rk_valid, output rk_ready);

endinterface

// File: rtl/key_expand_serial_rcon_gen.sv
// Round-constant register: reloads 0x01 on a new key and steps by xtime after each use.
module rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] rcon
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            rcon <= 8'h01;
        end else if (advance) begin
            rcon <= xtime(rcon);
        end
    end

endmodule

// File: rtl/key_expand_serial.sv
// Serial AES key expansion: one schedule word per cycle, round keys handed out
// over a valid/ready channel; the S-box array sits outside this block.
module key_expand_serial
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [32*NK-1:0] key,
    output logic [31:0]      sbox_in,
    input  logic [31:0]      sbox_out,
    output logic [127:0]     rk,
    output logic [3:0]       rk_idx,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             busy,
    output logic             done,
    output ks_state_e        fsm_state
);

    localparam int         NR      = NK + 6;
    localparam int         NW      = 4 * (NR + 1);
    localparam logic [2:0] NK_LAST = 3'(NK - 1);
    localparam logic [5:0] NW_CNT  = 6'(NW);

    if (!nk_legal(NK)) begin : g_nk_check
        $error("key_expand_serial: NK must be 4, 6 or 8");
    end

    ks_state_e           state, state_next;
    logic [NK-1:0][31:0] window;
    logic [1:0]          slot;
    logic [2:0]          nk_pos;
    logic                past_key;
    logic [5:0]          word_cnt;
    logic [7:0]          rcon;
    logic [31:0]         last_word, temp, w_new;
    logic                load, gen, next_round, rcon_step;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        gen        = 1'b0;
        next_round = 1'b0;
        rk_valid   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load       = 1'b1;
                    state_next = GEN;
                end
            end
            GEN: begin
                gen = 1'b1;
                if (slot == 2'd3) state_next = HOLD;
            end
            HOLD: begin
                rk_valid = 1'b1;
                if (rk_ready) begin
                    next_round = (word_cnt != NW_CNT);
                    state_next = (word_cnt == NW_CNT) ? FIN : GEN;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign fsm_state = state;

    // window[0] is w[i-NK], window[NK-1] is w[i-1]; before the key is exhausted
    // the rotating window simply replays the key words.
    assign last_word = window[NK-1];
    assign sbox_in   = (nk_pos == 3'd0) ? {last_word[7:0], last_word[31:8]} : last_word;
    assign rcon_step = gen && past_key && (nk_pos == 3'd0);

    always_comb begin
        temp = last_word;
        if (nk_pos == 3'd0)                  temp = sbox_out ^ {24'h0, rcon};
        else if (NK == 8 && nk_pos == 3'd4)  temp = sbox_out;
        w_new = past_key ? (window[0] ^ temp) : window[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            window   <= '0;
            rk       <= '0;
            rk_idx   <= '0;
            slot     <= '0;
            nk_pos   <= '0;
            past_key <= 1'b0;
            word_cnt <= '0;
        end else if (load) begin
            window   <= key;
            rk_idx   <= '0;
            slot     <= '0;
            nk_pos   <= '0;
            past_key <= 1'b0;
            word_cnt <= '0;
        end else begin
            if (gen) begin
                window            <= {w_new, window[NK-1:1]};
                rk[32*slot +: 32] <= w_new;
                slot              <= slot + 2'd1;
                nk_pos            <= (nk_pos == NK_LAST) ? 3'd0 : nk_pos + 3'd1;
                past_key          <= past_key || (nk_pos == NK_LAST);
                word_cnt          <= word_cnt + 6'd1;
            end
            if (next_round) rk_idx <= rk_idx + 4'd1;
        end
    end

    rcon_gen u_rcon (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (rcon_step),
        .rcon    (rcon)
    );

endmodule
